imem_loadable: RTL and testbench

//  Parametrised, synchronous, run-time loadable instruction memory for the pipelined ARM64 core's fetch stage.

---
 rtl/imem_loadable.sv | 173 +++++++++++++++++
 tb/tb_imem_loadable.sv | 226 ++++++++++++++++++++++
 2 files changed

// File: rtl/imem_loadable.sv
// imem_loadable: run-time loadable instruction memory for the fetch stage.
// On reset every word is filled with NOP_WORD, then the memory serves
// registered 1-cycle fetches with stall hold. A sequential load port
// rewrites the program from word 0.
// Optional feature macro: IMEM_HALT_DETECT_EN. When it is defined, the
// memory flags a fetch of HALT_WORD and blocks further fetches until reset
// or load_start.
//
// state   | meaning
// --------+--------------------------------------------------------
// S_CLEAR | writing NOP_WORD to mem[clr_ptr], one word per cycle
// S_RUN   | serving fetches; load_start moves to S_LOAD
// S_LOAD  | writing load_data at load_ptr; load_we&load_last ends it
module imem_loadable #(
   parameter int             N        = 32,
   parameter int             ADDR_W   = 7,
   parameter logic [N-1:0]   NOP_WORD = 32'h8b1f03ff
`ifdef IMEM_HALT_DETECT_EN
   ,
   parameter logic [N-1:0]   HALT_WORD = 32'hb400001f
`endif
) (
   input  logic              clk,
   input  logic              reset,
   input  logic              fetch_en,
   input  logic              stall,
   input  logic [ADDR_W-1:0] addr,
   output logic [N-1:0]      q,
   output logic              q_valid,
   input  logic              load_start,
   input  logic              load_we,
   input  logic [N-1:0]      load_data,
   input  logic              load_last,
   output logic              busy,
   output logic              load_err,
   output logic              halted
);

   localparam int DEPTH = 2 ** ADDR_W;

   typedef enum logic [1:0] {
      S_CLEAR = 2'd0,
      S_RUN   = 2'd1,
      S_LOAD  = 2'd2
   } state_t;

   state_t              state;
   state_t              state_nxt;
   logic [ADDR_W-1:0]   clr_ptr;
   logic [ADDR_W:0]     load_ptr;
   logic                load_in_range;
   logic                load_wr_ok;
   logic                fetch_ok;
   logic                halt_blk;
   logic                mem_we;
   logic [ADDR_W-1:0]   mem_waddr;
   logic [N-1:0]        mem_wdata;
   logic [N-1:0]        mem [DEPTH];

   // load_ptr never advances past DEPTH, so its top bit alone marks "full"
   assign load_in_range = ~load_ptr[ADDR_W];

   // load_start takes priority over a same-cycle load_we in LOAD
   assign load_wr_ok = (state == S_LOAD) & load_we & load_in_range & ~load_start;

`ifdef IMEM_HALT_DETECT_EN
   assign halt_blk = halted;
`else
   assign halt_blk = 1'b0;
`endif

   // a fetch is taken only in RUN, unstalled, and not displaced by load_start
   assign fetch_ok = (state == S_RUN) & ~stall & fetch_en & ~load_start & ~halt_blk;

   // state register
   always_ff @(posedge clk or negedge reset) begin
      if (!reset) state <= S_CLEAR;
      else        state <= state_nxt;
   end

   // next-state logic
   always_comb begin
      state_nxt = state;
      case (state)
         S_CLEAR: if (clr_ptr == ADDR_W'(DEPTH - 1)) state_nxt = S_RUN;
         S_RUN:   if (load_start) state_nxt = S_LOAD;
         S_LOAD: begin
            if (load_start)               state_nxt = S_LOAD;
            else if (load_we && load_last) state_nxt = S_RUN;
         end
         default: state_nxt = S_CLEAR;
      endcase
   end

   // outputs and memory write-port steering
   always_comb begin
      busy      = (state != S_RUN);
      mem_we    = 1'b0;
      mem_waddr = clr_ptr;
      mem_wdata = NOP_WORD;
      if (state == S_CLEAR) begin
         mem_we = 1'b1;
      end else if (load_wr_ok) begin
         mem_we    = 1'b1;
         mem_waddr = load_ptr[ADDR_W-1:0];
         mem_wdata = load_data;
      end
   end

   // storage array; contents are not reset, CLEAR rewrites them
   always_ff @(posedge clk) begin
      if (mem_we) mem[mem_waddr] <= mem_wdata;
   end

   // clear and load pointers, sticky load error
   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         clr_ptr  <= '0;
         load_ptr <= '0;
         load_err <= 1'b0;
      end else begin
         if (state == S_CLEAR) clr_ptr <= clr_ptr + 1'b1;
         if ((state == S_RUN || state == S_LOAD) && load_start) begin
            load_ptr <= '0;
            load_err <= 1'b0;
         end else if (state == S_LOAD && load_we) begin
            if (load_in_range) load_ptr <= load_ptr + 1'b1;
            else               load_err <= 1'b1;
         end
      end
   end

   // registered read with stall hold; q keeps its last word when not fetching
   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         q       <= '0;
         q_valid <= 1'b0;
      end else begin
         case (state)
            S_RUN: begin
               if (load_start) begin
                  q_valid <= 1'b0;
               end else if (!stall) begin
                  if (fetch_ok) begin
                     q       <= mem[addr];
                     q_valid <= 1'b1;
                  end else begin
                     q_valid <= 1'b0;
                  end
               end
            end
            S_LOAD:  q_valid <= 1'b0;
            default: q_valid <= 1'b0;
         endcase
      end
   end

`ifdef IMEM_HALT_DETECT_EN
   // sticky halt flag, raised together with q_valid of the halting word
   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         halted <= 1'b0;
      end else if ((state == S_RUN || state == S_LOAD) && load_start) begin
         halted <= 1'b0;
      end else if (fetch_ok && mem[addr] == HALT_WORD) begin
         halted <= 1'b1;
      end
   end
`else
   assign halted = 1'b0;
`endif

endmodule

// File: tb/tb_imem_loadable.sv
// Directed bench for imem_loadable with a reference memory model and an
// expected-data queue for fetched words.
module tb_imem_loadable;

   localparam int ADDR_W = 7;
   localparam int DEPTH  = 128;
   localparam logic [31:0] NOP  = 32'h8b1f03ff;
   localparam logic [31:0] HALT = 32'hb400001f;
`ifdef IMEM_HALT_DETECT_EN
   localparam bit HALT_EN = 1'b1;
`else
   localparam bit HALT_EN = 1'b0;
`endif

   logic              clk = 1'b0;
   logic              reset;
   logic              fetch_en;
   logic              stall;
   logic [ADDR_W-1:0] addr;
   logic [31:0]       q;
   logic              q_valid;
   logic              load_start;
   logic              load_we;
   logic [31:0]       load_data;
   logic              load_last;
   logic              busy;
   logic              load_err;
   logic              halted;

   int total = 0;
   int bad   = 0;
   logic [31:0] model [DEPTH];
   logic [31:0] prog  [200];
   logic [31:0] exp_q [$];

   imem_loadable dut (
      .clk        (clk),
      .reset      (reset),
      .fetch_en   (fetch_en),
      .stall      (stall),
      .addr       (addr),
      .q          (q),
      .q_valid    (q_valid),
      .load_start (load_start),
      .load_we    (load_we),
      .load_data  (load_data),
      .load_last  (load_last),
      .busy       (busy),
      .load_err   (load_err),
      .halted     (halted)
   );

   always #5 clk = ~clk;

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      total++;
      assert (obs === exp)
      else begin
         bad++;
         $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
      end
   endtask

   task automatic model_nop();
      for (int i = 0; i < DEPTH; i++) model[i] = NOP;
   endtask

   // counts cycles of busy after reset release; expects exactly DEPTH
   task automatic wait_clear();
      int cnt = 0;
      while (busy === 1'b1 && cnt < 300) begin
         @(negedge clk);
         cnt++;
      end
      chk("clear_cycles", cnt, DEPTH);
      chk("busy_after_clear", busy, 0);
   endtask

   // single fetch; expected word queued at issue, checked one cycle later
   task automatic do_fetch(input int a, input string tag);
      logic [31:0] e;
      fetch_en = 1'b1;
      addr     = ADDR_W'(a);
      exp_q.push_back(model[a]);
      @(negedge clk);
      fetch_en = 1'b0;
      e = exp_q.pop_front();
      chk({tag, "_q"}, q, e);
      chk({tag, "_qv"}, q_valid, 1);
   endtask

   // loads prog[0..n-1], load_last on the final word, checks load_err each step
   task automatic load_prog(input int n, input string tag);
      load_start = 1'b1;
      @(negedge clk);
      load_start = 1'b0;
      chk({tag, "_busy_load"}, busy, 1);
      chk({tag, "_qv_load"}, q_valid, 0);
      for (int i = 0; i < n; i++) begin
         load_we   = 1'b1;
         load_data = prog[i];
         load_last = (i == n - 1);
         if (i < DEPTH) model[i] = prog[i];
         @(negedge clk);
         chk({tag, "_err"}, load_err, (i >= DEPTH) ? 1 : 0);
      end
      load_we   = 1'b0;
      load_last = 1'b0;
      chk({tag, "_busy_done"}, busy, 0);
   endtask

   initial begin
      reset      = 1'b0;
      fetch_en   = 1'b0;
      stall      = 1'b0;
      addr       = '0;
      load_start = 1'b0;
      load_we    = 1'b0;
      load_data  = '0;
      load_last  = 1'b0;
      model_nop();

      // reset state
      #1;
      chk("rst_q", q, 0);
      chk("rst_qv", q_valid, 0);
      chk("rst_busy", busy, 1);
      chk("rst_err", load_err, 0);
      chk("rst_halted", halted, 0);
      repeat (3) @(negedge clk);
      reset = 1'b1;

      // T1: clear takes DEPTH cycles, every word reads NOP
      wait_clear();
      do_fetch(0, "t1_a0");
      do_fetch(64, "t1_a64");
      do_fetch(127, "t1_a127");
      @(negedge clk);
      chk("t1_idle_qv", q_valid, 0);
      chk("t1_idle_qhold", q, NOP);

      // T2: three-word load, fetch issued on the RUN entry cycle
      prog[0] = 32'hf8000001;
      prog[1] = 32'hf8008002;
      prog[2] = HALT;
      load_prog(3, "t2");
      do_fetch(1, "t2_a1");
      do_fetch(3, "t2_a3");

      // T3: stall holds q/q_valid while addr and fetch_en wander
      do_fetch(0, "t3_a0");
      stall = 1'b1;
      for (int i = 0; i < 4; i++) begin
         fetch_en = 1'($urandom_range(0, 1));
         addr     = ADDR_W'($urandom_range(0, DEPTH - 1));
         @(negedge clk);
         chk("t3_stall_q", q, 32'hf8000001);
         chk("t3_stall_qv", q_valid, 1);
      end
      stall = 1'b0;
      do_fetch(1, "t3_rel");

      // T4: 129 writes overflow; word 0 kept; load_start clears the error
      for (int i = 0; i < 129; i++) prog[i] = 32'ha0000000 + i;
      load_prog(129, "t4");
      chk("t4_err_sticky", load_err, 1);
      do_fetch(0, "t4_a0");
      do_fetch(127, "t4_a127");
      load_start = 1'b1;
      @(negedge clk);
      load_start = 1'b0;
      chk("t4_err_clr", load_err, 0);
      load_we   = 1'b1;
      load_last = 1'b1;
      load_data = 32'h11112222;
      model[0]  = 32'h11112222;
      @(negedge clk);
      load_we   = 1'b0;
      load_last = 1'b0;
      chk("t4_busy_done", busy, 0);
      do_fetch(0, "t4_rewrite");

      // T5: load_start beats same-cycle fetch, then reset mid-load
      fetch_en   = 1'b1;
      addr       = 7'd5;
      load_start = 1'b1;
      @(negedge clk);
      fetch_en   = 1'b0;
      load_start = 1'b0;
      chk("t5_qv", q_valid, 0);
      chk("t5_busy", busy, 1);
      load_we   = 1'b1;
      load_data = 32'hdeadbeef;
      @(negedge clk);
      load_we = 1'b0;
      reset   = 1'b0;
      #1;
      chk("t5_rst_q", q, 0);
      chk("t5_rst_busy", busy, 1);
      chk("t5_rst_qv", q_valid, 0);
      @(negedge clk);
      reset = 1'b1;
      model_nop();
      wait_clear();
      do_fetch(0, "t5_a0");
      do_fetch(2, "t5_a2");

      // T6: fetching the halt word
      prog[0] = 32'hf8000001;
      prog[1] = 32'hf8008002;
      prog[2] = HALT;
      load_prog(3, "t6");
      do_fetch(2, "t6_a2");
      chk("t6_halted", halted, HALT_EN ? 1 : 0);
      fetch_en = 1'b1;
      addr     = 7'd0;
      @(negedge clk);
      fetch_en = 1'b0;
      chk("t6_next_qv", q_valid, HALT_EN ? 0 : 1);
      chk("t6_halted_hold", halted, HALT_EN ? 1 : 0);

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
